// File: rtl/playfield_sprite_gen_if.sv
// Pixel-timing and register-write bus between the video/CPU side (master)
// and the playfield/sprite colour generator (slave).
//
// Strobe semantics: pixel_en is a one-cycle strobe per pixel column and
// in_image is only meaningful in a cycle where pixel_en is 1. reg_we is a
// one-cycle write strobe; reg_addr/reg_data are sampled only while it is 1.
// There is no back-pressure: every strobe is accepted in the cycle it is
// presented. color/coll_pf/coll_ss are registered and hold between strobes.
interface playfield_sprite_gen_if #(
    parameter int NUM_SPRITES = 2,
    parameter int COLOR_W     = 7
) ();
    logic                   pixel_en;
    logic                   in_image;
    logic                   reg_we;
    logic [4:0]             reg_addr;
    logic [7:0]             reg_data;
    logic [COLOR_W-1:0]     color;
    logic [NUM_SPRITES-1:0] coll_pf;
    logic                   coll_ss;

    modport master (
        output pixel_en, in_image, reg_we, reg_addr, reg_data,
        input  color, coll_pf, coll_ss
    );

    modport slave (
        input  pixel_en, in_image, reg_we, reg_addr, reg_data,
        output color, coll_pf, coll_ss
    );
endinterface

// File: rtl/playfield_sprite_gen.sv
// Playfield + sprite colour generator. Register writes land in shadow
// copies; active copies follow the shadows while the sampled in_image flag
// is low and freeze during a visible line, so writes take effect next line.
module playfield_sprite_gen #(
    parameter int PF_BITS     = 22,
    parameter int PIX_PER_BIT = 16,
    parameter int NUM_SPRITES = 2,
    parameter int COLOR_W     = 7,
    parameter int COL_W       = 10
) (
    input  logic                 raw_clk,
    input  logic                 reset,
    playfield_sprite_gen_if.slave bus
);
    localparam int XW     = 10;
    localparam int AW     = ((COL_W > XW) ? COL_W : XW) + 4;
    localparam int PIX_SH = $clog2(PIX_PER_BIT);
    localparam logic [AW-1:0] L_LEN = AW'(PF_BITS * PIX_PER_BIT);

    // shadow (CPU-written) and active (render-time) register copies
    logic [1:0]         mode_s, mode_a;
    logic [COLOR_W-1:0] fg_s, fg_a, bg_s, bg_a;
    logic [PF_BITS-1:0] pf_s, pf_a;
    logic [7:0]         gfx_s   [NUM_SPRITES];
    logic [7:0]         gfx_a   [NUM_SPRITES];
    logic [XW-1:0]      x_s     [NUM_SPRITES];
    logic [XW-1:0]      x_a     [NUM_SPRITES];
    logic [1:0]         scale_s [NUM_SPRITES];
    logic [1:0]         scale_a [NUM_SPRITES];
    logic [COLOR_W-1:0] scol_s  [NUM_SPRITES];
    logic [COLOR_W-1:0] scol_a  [NUM_SPRITES];

    logic [COL_W-1:0]       col;
    logic                   in_image_q;
    logic                   armed;       // a blanking strobe has been seen since reset
    logic [COLOR_W-1:0]     color_q;
    logic [NUM_SPRITES-1:0] coll_pf_q;
    logic                   coll_ss_q;

    logic [AW-1:0]          c;
    logic [AW-1:0]          pf_idx, x_ext, off;
    logic [PF_BITS-1:0]     pf_sh;
    logic [7:0]             gbits;
    logic [1:0]             sh;
    logic                   pf_in, pf_on, spr_any, multi, render, clr;
    logic [NUM_SPRITES-1:0] hit;
    logic [COLOR_W-1:0]     spr_color, pix;

    assign c      = AW'(col);
    assign render = bus.pixel_en & bus.in_image & armed;
    assign clr    = bus.reg_we & (bus.reg_addr == 5'h03);

    // register writes into the shadow copies
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            mode_s <= '0;
            fg_s   <= '0;
            bg_s   <= '0;
            pf_s   <= '0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                gfx_s[k]   <= '0;
                x_s[k]     <= '0;
                scale_s[k] <= '0;
                scol_s[k]  <= '0;
            end
        end else if (bus.reg_we) begin
            if (bus.reg_addr == 5'h00) mode_s <= bus.reg_data[1:0];
            if (bus.reg_addr == 5'h01) fg_s <= bus.reg_data[7 -: COLOR_W];
            if (bus.reg_addr == 5'h02) bg_s <= bus.reg_data[7 -: COLOR_W];
            // byte n covers pf[8n+7:8n]; bits past PF_BITS simply have no flop
            for (int i = 0; i < PF_BITS; i++) begin
                if (bus.reg_addr == 5'(4 + i / 8)) pf_s[i] <= bus.reg_data[i % 8];
            end
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (bus.reg_addr == 5'(16 + 4 * k)) gfx_s[k] <= bus.reg_data;
                if (bus.reg_addr == 5'(17 + 4 * k)) x_s[k][7:0] <= bus.reg_data;
                if (bus.reg_addr == 5'(18 + 4 * k)) begin
                    x_s[k][9:8] <= bus.reg_data[1:0];
                    scale_s[k]  <= bus.reg_data[3:2];
                end
                if (bus.reg_addr == 5'(19 + 4 * k)) scol_s[k] <= bus.reg_data[7 -: COLOR_W];
            end
        end
    end

    // active copies track the shadows outside the visible line
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            mode_a <= '0;
            fg_a   <= '0;
            bg_a   <= '0;
            pf_a   <= '0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                gfx_a[k]   <= '0;
                x_a[k]     <= '0;
                scale_a[k] <= '0;
                scol_a[k]  <= '0;
            end
        end else if (!in_image_q) begin
            mode_a  <= mode_s;
            fg_a    <= fg_s;
            bg_a    <= bg_s;
            pf_a    <= pf_s;
            gfx_a   <= gfx_s;
            x_a     <= x_s;
            scale_a <= scale_s;
            scol_a  <= scol_s;
        end
    end

    // pixel for the current column: playfield bit, sprite hits, priority mux
    always_comb begin
        pf_idx    = '0;
        pf_in     = 1'b0;
        pf_sh     = '0;
        pf_on     = 1'b0;
        hit       = '0;
        x_ext     = '0;
        off       = '0;
        sh        = '0;
        gbits     = '0;
        spr_any   = 1'b0;
        spr_color = '0;
        multi     = 1'b0;
        pix       = '0;

        if (c < L_LEN) begin
            pf_in  = 1'b1;
            pf_idx = AW'(PF_BITS - 1) - (c >> PIX_SH);
        end else if (c < (L_LEN << 1)) begin
            pf_in  = 1'b1;
            pf_idx = mode_a[0] ? AW'(PF_BITS - 1) - ((c - L_LEN) >> PIX_SH)
                               : ((c - L_LEN) >> PIX_SH);
        end
        pf_sh = pf_a >> pf_idx;
        pf_on = pf_in & pf_sh[0];

        // scale code 2 and 3 both mean 4x, i.e. a shift of 2
        for (int k = 0; k < NUM_SPRITES; k++) begin
            x_ext  = AW'(x_a[k]);
            sh     = (scale_a[k] == 2'd0) ? 2'd0 : (scale_a[k] == 2'd1) ? 2'd1 : 2'd2;
            off    = c - x_ext;
            gbits  = gfx_a[k] << (off >> sh);
            hit[k] = (c >= x_ext) && (off < (AW'(8) << sh)) && gbits[7];
        end

        // walk downwards so the lowest-index hit is the one left standing
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                spr_any   = 1'b1;
                spr_color = scol_a[k];
            end
        end
        multi = ($countones(hit) > 1);

        if (mode_a[1]) pix = pf_on ? fg_a : (spr_any ? spr_color : bg_a);
        else           pix = spr_any ? spr_color : (pf_on ? fg_a : bg_a);
    end

    // column counter, line arming and registered colour output
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            col        <= '0;
            in_image_q <= 1'b0;
            armed      <= 1'b0;
            color_q    <= '0;
        end else if (bus.pixel_en) begin
            in_image_q <= bus.in_image;
            if (bus.in_image) begin
                if (col != '1) col <= col + 1'b1;
                color_q <= armed ? pix : '0;
            end else begin
                col     <= '0;
                color_q <= '0;
                armed   <= 1'b1;
            end
        end
    end

    // sticky collision flags; a set in the same cycle as a clear wins
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            coll_pf_q <= '0;
            coll_ss_q <= 1'b0;
        end else begin
            coll_pf_q <= (clr ? '0 : coll_pf_q) | (render ? (hit & {NUM_SPRITES{pf_on}}) : '0);
            coll_ss_q <= (clr ? 1'b0 : coll_ss_q) | (render & multi);
        end
    end

    assign bus.color   = color_q;
    assign bus.coll_pf = coll_pf_q;
    assign bus.coll_ss = coll_ss_q;
endmodule

// File: tb/tb_playfield_sprite_gen.sv
// Bench for playfield_sprite_gen: directed lines from the test plan plus
// randomised lines, checked against a column-level reference model.
module tb_playfield_sprite_gen;
    localparam int PF_BITS = 22;
    localparam int PIX     = 16;
    localparam int NS      = 2;
    localparam int CW      = 7;
    localparam int COL_W   = 10;
    localparam int W       = 1 + NS + CW;

    // ---------------- clock / reset ----------------
    logic raw_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 raw_clk = ~raw_clk;

    playfield_sprite_gen_if #(.NUM_SPRITES(NS), .COLOR_W(CW)) bus ();

    playfield_sprite_gen #(
        .PF_BITS(PF_BITS), .PIX_PER_BIT(PIX), .NUM_SPRITES(NS),
        .COLOR_W(CW), .COL_W(COL_W)
    ) dut (
        .raw_clk(raw_clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (line %0d col %0d): got %h, expected %h", name, tag / 4096, tag % 4096, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]    sh_mode, a_mode;
    logic [CW-1:0] sh_fg, sh_bg, a_fg, a_bg;
    logic [31:0]   sh_pf, a_pf;
    logic [7:0]    sh_gfx[NS], a_gfx[NS];
    int            sh_x[NS], a_x[NS], sh_sc[NS], a_sc[NS];
    logic [CW-1:0] sh_scol[NS], a_scol[NS];
    int            m_col, line_no;
    bit            m_iiq, m_armed, m_css;
    logic [NS-1:0] m_cpf;

    task automatic model_reset();
        sh_mode = '0; sh_fg = '0; sh_bg = '0; sh_pf = '0;
        a_mode = '0; a_fg = '0; a_bg = '0; a_pf = '0;
        for (int k = 0; k < NS; k++) begin
            sh_gfx[k] = '0; sh_x[k] = 0; sh_sc[k] = 0; sh_scol[k] = '0;
            a_gfx[k] = '0; a_x[k] = 0; a_sc[k] = 0; a_scol[k] = '0;
        end
        m_col = 0; m_iiq = 0; m_armed = 0; m_css = 0; m_cpf = '0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [7:0] d);
        int n, k, f;
        if (a == 5'h00) sh_mode = d[1:0];
        if (a == 5'h01) sh_fg = d[7 -: CW];
        if (a == 5'h02) sh_bg = d[7 -: CW];
        if (a == 5'h03) begin m_cpf = '0; m_css = 0; end
        if (a >= 5'h04 && a <= 5'h07) begin
            n = int'(a) - 4;
            for (int b = 0; b < 8; b++) if (8 * n + b < PF_BITS) sh_pf[8 * n + b] = d[b];
        end
        if (a >= 5'h10) begin
            k = (int'(a) - 16) / 4;
            f = (int'(a) - 16) % 4;
            if (k < NS) begin
                if (f == 0) sh_gfx[k] = d;
                if (f == 1) sh_x[k] = (sh_x[k] & 'h300) | int'(d);
                if (f == 2) begin
                    sh_x[k]  = (sh_x[k] & 'hFF) | (int'(d[1:0]) << 8);
                    sh_sc[k] = int'(d[3:2]);
                end
                if (f == 3) sh_scol[k] = d[7 -: CW];
            end
        end
    endtask

    task automatic model_pixel(input int c, output logic [CW-1:0] px, output logic [NS-1:0] spf, output bit sss);
        int  len, d, s, win, cnt;
        bit  pf_on;
        len = PF_BITS * PIX; pf_on = 0; win = -1; cnt = 0; spf = '0;
        if (c < len) pf_on = a_pf[PF_BITS - 1 - c / PIX];
        else if (c < 2 * len) begin
            d = (c - len) / PIX;
            pf_on = a_mode[0] ? a_pf[PF_BITS - 1 - d] : a_pf[d];
        end
        for (int k = 0; k < NS; k++) begin
            s = (a_sc[k] == 0) ? 1 : (a_sc[k] == 1) ? 2 : 4;
            if (c >= a_x[k] && c < a_x[k] + 8 * s) begin
                if (a_gfx[k][7 - (c - a_x[k]) / s]) begin
                    cnt++;
                    if (win < 0) win = k;
                    if (pf_on) spf[k] = 1'b1;
                end
            end
        end
        sss = (cnt >= 2);
        if (a_mode[1]) px = pf_on ? a_fg : ((win >= 0) ? a_scol[win] : a_bg);
        else           px = (win >= 0) ? a_scol[win] : (pf_on ? a_fg : a_bg);
    endtask

    task automatic model_step(input bit pe, input bit ii, input bit we, input logic [4:0] a,
                              input logic [7:0] d, input bit rst);
        logic [CW-1:0] px;
        logic [NS-1:0] set_pf;
        bit            set_ss;
        int            c;
        px = '0; set_pf = '0; set_ss = 0; c = -1;
        if (rst) begin
            model_reset();
            return;
        end
        if (pe) begin
            if (ii && !m_iiq) begin
                a_mode = sh_mode; a_fg = sh_fg; a_bg = sh_bg; a_pf = sh_pf;
                a_gfx = sh_gfx; a_x = sh_x; a_sc = sh_sc; a_scol = sh_scol;
            end
            if (!ii) begin
                m_col = 0;
                m_armed = 1;
            end else begin
                c = m_col;
                if (m_armed) model_pixel(m_col, px, set_pf, set_ss);
                if (m_col < (1 << COL_W) - 1) m_col++;
            end
            m_iiq = ii;
        end
        if (we) model_write(a, d);
        m_cpf = m_cpf | set_pf;
        m_css = m_css | set_ss;
        if (pe) begin
            exp_q.push_back({m_css, m_cpf, px});
            tag_q.push_back(line_no * 4096 + ((c < 0) ? 4095 : c));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Each call occupies one clock: inputs set at a negedge, sampled at the
    // following posedge, and the call returns on the next negedge.
    task automatic cycle(input bit pe, input bit ii, input bit we, input logic [4:0] a,
                         input logic [7:0] d, input bit rst);
        bus.pixel_en = pe; bus.in_image = ii; bus.reg_we = we;
        bus.reg_addr = a;  bus.reg_data = d;  reset = rst;
        model_step(pe, ii, we, a, d, rst);
        @(posedge raw_clk);
        @(negedge raw_clk);
        bus.pixel_en = 1'b0; bus.in_image = 1'b0; bus.reg_we = 1'b0; reset = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 5'h00, 8'h00, 0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cycle(0, 0, 1, a, d, 0);
    endtask

    task automatic wrc(input logic [4:0] a, input logic [CW-1:0] v);
        logic [7:0] d;
        d = 8'(v) << (8 - CW);
        wr(a, d);
    endtask

    // Blanking strobes, n visible columns, closing blanking strobe. At column
    // ev_col either a register write rides on the pixel strobe or, with
    // ev_rst, a reset cycle is inserted before it.
    task automatic run_line(input int n, input int ev_col, input logic [4:0] ev_a,
                            input logic [7:0] ev_d, input bit ev_rst);
        repeat (3) begin
            idle();
            cycle(1, 0, 0, 5'h00, 8'h00, 0);
        end
        for (int c = 0; c < n; c++) begin
            idle();
            if (c == ev_col && ev_rst) begin
                cycle(0, 1, 0, 5'h00, 8'h00, 1);
                check("color after reset", line_no * 4096 + c, 32'(bus.color), 32'd0);
                check("coll_pf after reset", line_no * 4096 + c, 32'(bus.coll_pf), 32'd0);
                check("coll_ss after reset", line_no * 4096 + c, 32'(bus.coll_ss), 32'd0);
            end
            if (c == ev_col && !ev_rst) cycle(1, 1, 1, ev_a, ev_d, 0);
            else                        cycle(1, 1, 0, 5'h00, 8'h00, 0);
        end
        idle();
        cycle(1, 0, 0, 5'h00, 8'h00, 0);
        line_no++;
    endtask

    task automatic random_regs();
        wr(5'h00, 8'($urandom_range(0, 3)));
        wr(5'h01, 8'($urandom));
        wr(5'h02, 8'($urandom));
        for (int a = 4; a < 8; a++) wr(5'(a), 8'($urandom));
        for (int k = 0; k < 3; k++) begin
            wr(5'(16 + 4 * k), 8'($urandom));
            wr(5'(17 + 4 * k), 8'($urandom));
            wr(5'(18 + 4 * k), 8'($urandom_range(0, 15)));
            wr(5'(19 + 4 * k), 8'($urandom));
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        int           t;
        forever begin
            @(posedge raw_clk);
            if (bus.pixel_en === 1'b1) begin
                @(negedge raw_clk);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pixel: DUT strobe with empty expectation queue, got %h", {bus.coll_ss, bus.coll_pf, bus.color});
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check("pixel {ss,pf,color}", t, 32'({bus.coll_ss, bus.coll_pf, bus.color}), 32'(e));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        line_no = 0;
        model_reset();
        bus.pixel_en = 1'b0; bus.in_image = 1'b0; bus.reg_we = 1'b0;
        bus.reg_addr = '0;   bus.reg_data = '0;
        @(negedge raw_clk);
        cycle(0, 0, 0, 5'h00, 8'h00, 1);
        cycle(0, 0, 0, 5'h00, 8'h00, 1);
        check("reset color", 0, 32'(bus.color), 32'd0);
        check("reset coll_pf", 0, 32'(bus.coll_pf), 32'd0);
        check("reset coll_ss", 0, 32'(bus.coll_ss), 32'd0);

        // mirrored playfield, only pf[21] set
        wr(5'h00, 8'h00);
        wrc(5'h01, 7'h10);
        wrc(5'h02, 7'h02);
        wr(5'h06, 8'h20);
        run_line(720, -1, 5'h00, 8'h00, 0);

        // repeated playfield
        wr(5'h00, 8'h01);
        run_line(720, -1, 5'h00, 8'h00, 0);

        // sprite 0 alone, 2x scale, graphic 0x81 at X=100
        wr(5'h00, 8'h00);
        wr(5'h06, 8'h00);
        wr(5'h10, 8'h81);
        wr(5'h11, 8'd100);
        wr(5'h12, 8'h04);
        wrc(5'h13, 7'h40);
        run_line(200, -1, 5'h00, 8'h00, 0);

        // sprite 0 over pf[21] at X=0, both priorities, then clears
        wr(5'h06, 8'h20);
        wr(5'h11, 8'd0);
        run_line(20, -1, 5'h00, 8'h00, 0);
        check("coll_pf after overlap mode0", 0, 32'(bus.coll_pf), 32'(m_cpf));
        wr(5'h03, 8'h00);
        check("coll_pf after clear", 0, 32'(bus.coll_pf), 32'd0);
        wr(5'h00, 8'h02);
        run_line(20, -1, 5'h00, 8'h00, 0);
        check("coll_pf after overlap mode2", 0, 32'(bus.coll_pf), 32'(m_cpf));
        wr(5'h03, 8'h5A);
        check("coll_pf after second clear", 0, 32'(bus.coll_pf), 32'd0);
        run_line(20, 0, 5'h03, 8'h00, 0);
        check("coll_pf clear vs set same cycle", 0, 32'(bus.coll_pf), 32'(m_cpf));

        // mid-line fg change only shows on the following line
        wr(5'h00, 8'h00);
        wr(5'h10, 8'h00);
        run_line(720, 200, 5'h01, 8'h60, 0);
        run_line(720, -1, 5'h00, 8'h00, 0);

        // sprite 2 does not exist; its addresses must do nothing
        wr(5'h18, 8'hFF);
        wr(5'h19, 8'd5);
        wr(5'h1B, 8'hFE);
        run_line(64, -1, 5'h00, 8'h00, 0);

        // randomised registers and mid-line writes
        for (int i = 0; i < 5; i++) begin
            random_regs();
            run_line(720, $urandom_range(0, 719), 5'($urandom), 8'($urandom), 0);
        end

        // reset in the middle of a line with flags set
        wr(5'h00, 8'h00);
        wr(5'h04, 8'h00);
        wr(5'h05, 8'h00);
        wr(5'h06, 8'h20);
        wr(5'h10, 8'h81); wr(5'h11, 8'd0); wr(5'h12, 8'h00); wrc(5'h13, 7'h40);
        wr(5'h14, 8'h80); wr(5'h15, 8'd0); wr(5'h16, 8'h00); wrc(5'h17, 7'h22);
        run_line(400, 300, 5'h00, 8'h00, 1);
        run_line(50, -1, 5'h00, 8'h00, 0);

        repeat (4) idle();
        check("expectation queue drained", 0, 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
